// File: rtl/mod_sched_rr.sv
// -----------------------------------------------------------------------------
// mod_sched_rr
// Shares one iterative modulo-reduction datapath (one subtraction of MODULUS
// per clock) between NREQ requesters. Requests are granted round-robin from
// IDLE, reduced in REDUCE, and reported for one cycle in DONE together with the
// requester's id and a one-hot ack. Only one reduction is in flight at a time.
//
// Ports
//   clock        in   1          rising-edge clock
//   reset        in   1          asynchronous, active-high reset
//   req          in   NREQ       req[k]=1: requester k has an operand pending
//   operand      in   NREQ*W     requester k operand in bits [k*W +: W]
//   ack          out  NREQ       one-cycle one-hot pulse to the served requester
//   result       out  W          operand mod MODULUS, valid with result_valid
//   result_valid out  1          one-cycle pulse; result/result_id are valid
//   result_id    out  IDW        index of the served requester
//   busy         out  1          high whenever the scheduler is not idle
// -----------------------------------------------------------------------------
module mod_sched_rr #(
    parameter  int W       = 8,
    parameter  int NREQ    = 4,
    parameter  int MODULUS = 14,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] operand,
    output logic [NREQ-1:0]   ack,
    output logic [W-1:0]      result,
    output logic              result_valid,
    output logic [IDW-1:0]    result_id,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [W-1:0]    MOD_W     = W'(MODULUS);
    localparam logic [IDW-1:0]  LAST_INIT = IDW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0  = {{(NREQ-1){1'b0}}, 1'b1};

    // Registered state
    state_t          r_state;
    logic [W-1:0]    r_acc;
    logic [IDW-1:0]  r_id;
    logic [IDW-1:0]  r_last;
    logic [W-1:0]    r_result;
    logic [IDW-1:0]  r_result_id;
    logic            r_result_valid;
    logic [NREQ-1:0] r_ack;

    // Next-state values
    state_t          w_state_nxt;
    logic [W-1:0]    w_acc_nxt;
    logic [IDW-1:0]  w_id_nxt;
    logic [IDW-1:0]  w_last_nxt;
    logic [W-1:0]    w_result_nxt;
    logic [IDW-1:0]  w_result_id_nxt;
    logic            w_result_valid_nxt;
    logic [NREQ-1:0] w_ack_nxt;

    // Arbitration
    logic            w_grant_found;
    logic [IDW-1:0]  w_grant_id;
    logic [W-1:0]    w_grant_op;
    int              w_scan_idx;

    // Round-robin scan: first set request bit starting just after the last
    // served requester, wrapping modulo NREQ, so the last winner ranks lowest.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_id    = '0;
        w_scan_idx    = 0;
        for (int i = 1; i <= NREQ; i++) begin
            w_scan_idx = (int'(r_last) + i) % NREQ;
            if (!w_grant_found && req[w_scan_idx[IDW-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_id    = w_scan_idx[IDW-1:0];
            end else begin
                w_grant_found = w_grant_found;
                w_grant_id    = w_grant_id;
            end
        end
    end

    // Operand of the winning requester, latched only on the grant edge.
    always_comb begin
        w_grant_op = operand[int'(w_grant_id)*W +: W];
    end

    // FSM next-state and registered-output next values.
    always_comb begin
        w_state_nxt        = r_state;
        w_acc_nxt          = r_acc;
        w_id_nxt           = r_id;
        w_last_nxt         = r_last;
        w_result_nxt       = r_result;
        w_result_id_nxt    = r_result_id;
        w_result_valid_nxt = 1'b0;
        w_ack_nxt          = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_found) begin
                    w_acc_nxt   = w_grant_op;
                    w_id_nxt    = w_grant_id;
                    w_state_nxt = ST_REDUCE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REDUCE: begin
                // acc >= MODULUS guarantees the subtraction cannot wrap.
                if (r_acc >= MOD_W) begin
                    w_acc_nxt = r_acc - MOD_W;
                end else begin
                    w_result_nxt       = r_acc;
                    w_result_id_nxt    = r_id;
                    w_result_valid_nxt = 1'b1;
                    w_ack_nxt          = ONE_HOT0 << r_id;
                    w_last_nxt         = r_id;
                    w_state_nxt        = ST_DONE;
                end
            end
            ST_DONE: begin
                // Dead cycle: pulses drop, no grant is considered here.
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_acc          <= '0;
            r_id           <= '0;
            r_last         <= LAST_INIT;
            r_result       <= '0;
            r_result_id    <= '0;
            r_result_valid <= 1'b0;
            r_ack          <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_acc          <= w_acc_nxt;
            r_id           <= w_id_nxt;
            r_last         <= w_last_nxt;
            r_result       <= w_result_nxt;
            r_result_id    <= w_result_id_nxt;
            r_result_valid <= w_result_valid_nxt;
            r_ack          <= w_ack_nxt;
        end
    end

    assign ack          = r_ack;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign result_id    = r_result_id;
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mod_sched_rr.sv
// -----------------------------------------------------------------------------
// tb_mod_sched_rr
// Directed bench for mod_sched_rr. A job-level reference model (division and
// remainder, a countdown until completion) predicts every output each cycle;
// directed scenarios also check hand-computed ids, results and latencies.
// -----------------------------------------------------------------------------
module tb_mod_sched_rr;

    localparam int W       = 8;
    localparam int NREQ    = 4;
    localparam int MODULUS = 14;
    localparam int IDW     = 2;

    logic              clock;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] operand;
    logic [NREQ-1:0]   ack;
    logic [W-1:0]      result;
    logic              result_valid;
    logic [IDW-1:0]    result_id;
    logic              busy;

    logic [NREQ-1:0]   keep;
    bit                cmp_en;
    int                checks;
    int                failures;

    mod_sched_rr #(.W(W), .NREQ(NREQ), .MODULUS(MODULUS)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .operand      (operand),
        .ack          (ack),
        .result       (result),
        .result_valid (result_valid),
        .result_id    (result_id),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Round-robin pick: first pending requester after 'last', wrapping.
    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        int g;
        g = -1;
        for (int i = 1; i <= NREQ; i++) begin
            if (g < 0 && r[(last + i) % NREQ]) g = (last + i) % NREQ;
        end
        return g;
    endfunction

    // ---------------- reference model (job level) ----------------
    bit m_busy;
    bit m_valid;
    int m_ack;
    int m_res;
    int m_rid;
    int m_last = NREQ - 1;
    int m_left;
    int m_x;
    int m_id;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_ack   <= 0;
            m_res   <= 0;
            m_rid   <= 0;
            m_last  <= NREQ - 1;
            m_left  <= 0;
        end else if (m_valid) begin
            m_valid <= 1'b0;
            m_ack   <= 0;
            m_busy  <= 1'b0;
        end else if (m_busy) begin
            if (m_left == 0) begin
                m_res   <= m_x % MODULUS;
                m_rid   <= m_id;
                m_valid <= 1'b1;
                m_ack   <= 1 << m_id;
                m_last  <= m_id;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (req != '0) begin
            m_id   <= rr_pick(req, m_last);
            m_x    <= int'(operand[rr_pick(req, m_last)*W +: W]);
            m_left <= int'(operand[rr_pick(req, m_last)*W +: W]) / MODULUS;
            m_busy <= 1'b1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        if (cmp_en) begin
            chk("cyc result_valid", int'(result_valid), int'(m_valid));
            chk("cyc ack", int'(ack), m_ack);
            chk("cyc busy", int'(busy), int'(m_busy));
            chk("cyc result", int'(result), m_res);
            chk("cyc result_id", int'(result_id), m_rid);
        end
    end

    // One cycle; requesters not marked 'keep' drop req once they see ack.
    task automatic step();
        @(negedge clock);
        for (int k = 0; k < NREQ; k++) begin
            if (ack[k] && !keep[k]) req[k] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic set_op(input int k, input int v);
        operand[k*W +: W] = W'(v);
    endtask

    // Waits for the next result pulse and checks it; exp_steps<0 skips latency.
    task automatic wait_result(input string tag, input int exp_id, input int exp_res,
                               input int exp_steps);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            step();
            n++;
            if (result_valid) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: no result_valid within %0d cycles, expected one", tag, n);
        end else begin
            chk({tag, " id"}, int'(result_id), exp_id);
            chk({tag, " result"}, int'(result), exp_res);
            chk({tag, " ack"}, int'(ack), 1 << exp_id);
            if (exp_steps >= 0) chk({tag, " latency"}, n, exp_steps);
        end
    endtask

    initial begin
        int cnt;
        checks   = 0;
        failures = 0;
        cmp_en   = 1'b0;
        reset    = 1'b1;
        req      = '0;
        operand  = '0;
        keep     = '0;
        repeat (2) @(negedge clock);
        reset  = 1'b0;
        cmp_en = 1'b1;
        chk("reset busy", int'(busy), 0);
        chk("reset result_valid", int'(result_valid), 0);

        // 1: 20 mod 14 = 6, valid after G+2
        set_op(0, 20); req = 4'b0001;
        wait_result("T1", 0, 6, 3);
        step();
        // 2: below modulus and worst case
        set_op(0, 5); req = 4'b0001;
        wait_result("T2a", 0, 5, 2);
        step();
        set_op(0, 255); req = 4'b0001;
        wait_result("T2b", 0, 3, 20);
        step();

        // 3: all four requesting, req0 held after its ack
        do_reset();
        set_op(0, 14); set_op(1, 15); set_op(2, 27); set_op(3, 0);
        keep = 4'b0001; req = 4'b1111;
        wait_result("T3a", 0, 0, 3);
        wait_result("T3b", 1, 1, -1);
        wait_result("T3c", 2, 13, -1);
        wait_result("T3d", 3, 0, -1);
        keep = '0;
        wait_result("T3e", 0, 0, -1);
        repeat (3) step();

        // 4: id1 served and kept, id2 arrives -> id2 then id1
        do_reset();
        set_op(1, 30); keep = 4'b0010; req = 4'b0010;
        wait_result("T4a", 1, 2, 4);
        set_op(2, 9); req[2] = 1'b1;
        wait_result("T4b", 2, 9, -1);
        keep = '0;
        wait_result("T4c", 1, 2, -1);
        step();

        // 5: reset in the middle of a reduction of 200
        set_op(0, 200); req = 4'b0001;
        repeat (5) step();
        #2 reset = 1'b1;
        #1;
        chk("T5 async result_valid", int'(result_valid), 0);
        chk("T5 async ack", int'(ack), 0);
        chk("T5 async result", int'(result), 0);
        chk("T5 async result_id", int'(result_id), 0);
        chk("T5 async busy", int'(busy), 0);
        @(negedge clock);
        reset = 1'b0;
        set_op(3, 7); req = 4'b1001;
        wait_result("T5a", 0, 4, 16);
        wait_result("T5b", 3, 7, -1);
        step();

        // 6: operand changes and req drops right after the grant
        set_op(2, 50); req = 4'b0100;
        step();
        set_op(2, 3); req = 4'b0000;
        wait_result("T6", 2, 8, 4);
        cnt = 0;
        repeat (8) begin
            step();
            if (result_valid) cnt++;
        end
        chk("T6 extra pulses", cnt, 0);
        chk("T6 idle", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
